// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared state encoding and width limits for the serial add/sub unit
package addsub_pkg;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa_slice.sv
// rtl/fa_slice.sv - combinational 1-bit full adder slice
module fa_slice (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - bit-serial WIDTH-bit add/subtract, one bit per clock
module serial_addsub
  import addsub_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_res;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_s;
  logic             w_c;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  fa_slice u_fa (
    .a     (r_a[0]),
    .b     (r_b[0]),
    .c_in  (r_carry),
    .sum   (w_s),
    .c_out (w_c)
  );

  // The partial result keeps only the WIDTH-1 bits already produced; the MSB arrives on the last cycle.
  assign w_res_next = {w_s, r_res};
  assign w_last     = (r_cnt == LAST_BIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub | cin;
            r_res   <= '0;
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_res   <= w_res_next[WIDTH-1:1];
          r_carry <= w_c;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            // r_carry is the carry into the MSB at this point.
            r_sum   <= w_res_next;
            r_cout  <= w_c;
            r_ovf   <= r_carry ^ w_c;
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;
  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - self-checking bench for serial_addsub at WIDTH=8 and WIDTH=2
module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, sub8, cin8;
  logic [7:0] a8, b8, sum8;
  logic       cout8, ovf8, busy8, done8;
  logic       start2, sub2, cin2;
  logic [1:0] a2, b2, sum2;
  logic       cout2, ovf2, busy2, done2;

  int n_chk = 0;
  int n_err = 0;
  int n_overlap = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .cin(cin8),
    .a(a8), .b(b8), .sum(sum8), .cout(cout8), .ovf(ovf8),
    .busy(busy8), .done(done8)
  );

  serial_addsub #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .sub(sub2), .cin(cin2),
    .a(a2), .b(b2), .sum(sum2), .cout(cout2), .ovf(ovf2),
    .busy(busy2), .done(done2)
  );

  always @(negedge clk) begin
    if ((busy8 && done8) || (busy2 && done2)) n_overlap++;
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic       sub;
    logic       cin;
    logic [1:0] sum;
    logic       cout;
    logic       ovf;
  } vec2_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Arithmetic reference: plain modular addition on the effective operands.
  function automatic void model(input int w, input longint unsigned a, input longint unsigned b,
                                input bit s, input bit c, output longint unsigned sm,
                                output bit co, output bit ov);
    longint unsigned mask;
    longint unsigned bb;
    longint unsigned tot;
    bit sa, sb, ss;
    mask = (64'd1 << w) - 64'd1;
    bb   = s ? (~b & mask) : (b & mask);
    tot  = (a & mask) + bb + (s ? 64'd1 : {63'd0, c});
    sm   = tot & mask;
    co   = ((tot >> w) & 64'd1) != 0;
    sa   = ((a  >> (w - 1)) & 64'd1) != 0;
    sb   = ((bb >> (w - 1)) & 64'd1) != 0;
    ss   = ((sm >> (w - 1)) & 64'd1) != 0;
    ov   = (sa == sb) && (ss != sa);
  endfunction

  task automatic scramble8();
    a8   = 8'($urandom);
    b8   = 8'($urandom);
    sub8 = 1'($urandom);
    cin8 = 1'($urandom);
  endtask

  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic c);
    @(negedge clk);
    a8 = a; b8 = b; sub8 = s; cin8 = c; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    scramble8();
  endtask

  // t=0 is 1ns after the start edge; done is expected at t=WIDTH.
  task automatic measure8(input int ign_at, output int done_at, output int busy_n);
    done_at = -1;
    busy_n  = 0;
    for (int t = 0; t < 32; t++) begin
      if (done8) begin
        done_at = t;
        break;
      end
      if (busy8) busy_n++;
      if (t == ign_at) begin
        scramble8();
        start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    start8 = 1'b0;
  endtask

  task automatic op8(input string name, input logic [7:0] a, input logic [7:0] b,
                     input logic s, input logic c, input logic [7:0] e_sum,
                     input logic e_cout, input logic e_ovf, input int ign_at);
    int d, bz;
    launch8(a, b, s, c);
    measure8(ign_at, d, bz);
    check({name, " done_at"}, 64'(d), 64'd8);
    check({name, " busy_cycles"}, 64'(bz), 64'd8);
    check({name, " sum"}, 64'(sum8), 64'(e_sum));
    check({name, " cout"}, 64'(cout8), 64'(e_cout));
    check({name, " ovf"}, 64'(ovf8), 64'(e_ovf));
    @(posedge clk);
    #1;
    check({name, " done_pulse_end"}, 64'(done8), 64'd0);
    check({name, " sum_held"}, 64'(sum8), 64'(e_sum));
  endtask

  task automatic op2(input string name, input vec2_t v);
    int d, bz;
    d  = -1;
    bz = 0;
    @(negedge clk);
    a2 = v.a; b2 = v.b; sub2 = v.sub; cin2 = v.cin; start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    a2 = 2'($urandom); b2 = 2'($urandom);
    for (int t = 0; t < 16; t++) begin
      if (done2) begin
        d = t;
        break;
      end
      if (busy2) bz++;
      @(posedge clk);
      #1;
    end
    check({name, " done_at"}, 64'(d), 64'd2);
    check({name, " busy_cycles"}, 64'(bz), 64'd2);
    check({name, " sum"}, 64'(sum2), 64'(v.sum));
    check({name, " cout"}, 64'(cout2), 64'(v.cout));
    check({name, " ovf"}, 64'(ovf2), 64'(v.ovf));
  endtask

  initial begin
    vec_t  vecs[7];
    vec2_t vecs2[2];
    longint unsigned m_sum;
    bit m_co, m_ov;
    logic [7:0] ra, rb;
    logic rs, rc;
    int d1, d2, bz, n_done;

    vecs[0] = '{a: 8'h5A, b: 8'h33, sub: 1'b0, cin: 1'b0, sum: 8'h8D, cout: 1'b0, ovf: 1'b1};
    vecs[1] = '{a: 8'hFF, b: 8'h01, sub: 1'b0, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 8'hFF, b: 8'h01, sub: 1'b0, cin: 1'b1, sum: 8'h01, cout: 1'b1, ovf: 1'b0};
    vecs[3] = '{a: 8'h10, b: 8'h20, sub: 1'b1, cin: 1'b0, sum: 8'hF0, cout: 1'b0, ovf: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h01, sub: 1'b1, cin: 1'b0, sum: 8'h7F, cout: 1'b1, ovf: 1'b1};
    vecs[5] = '{a: 8'h7F, b: 8'h01, sub: 1'b0, cin: 1'b0, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
    vecs[6] = '{a: 8'h05, b: 8'h05, sub: 1'b1, cin: 1'b1, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs2[0] = '{a: 2'b11, b: 2'b01, sub: 1'b0, cin: 1'b1, sum: 2'b01, cout: 1'b1, ovf: 1'b0};
    vecs2[1] = '{a: 2'b01, b: 2'b10, sub: 1'b1, cin: 1'b0, sum: 2'b11, cout: 1'b0, ovf: 1'b1};

    rst = 1'b1;
    start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    start2 = 1'b0; sub2 = 1'b0; cin2 = 1'b0; a2 = '0; b2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset sum8", 64'(sum8), 64'd0);
    check("reset cout8", 64'(cout8), 64'd0);
    check("reset ovf8", 64'(ovf8), 64'd0);
    check("reset busy8", 64'(busy8), 64'd0);
    check("reset done8", 64'(done8), 64'd0);
    check("reset sum2", 64'(sum2), 64'd0);
    check("reset busy2", 64'(busy2), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      op8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin,
          vecs[i].sum, vecs[i].cout, vecs[i].ovf, -1);

    op8("ignore_start", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1, 2);

    // Start held through DONE chains a second operation.
    launch8(8'h5A, 8'h33, 1'b0, 1'b0);
    measure8(-1, d1, bz);
    check("b2b first done_at", 64'(d1), 64'd8);
    check("b2b first sum", 64'(sum8), 64'h8D);
    a8 = 8'h10; b8 = 8'h20; sub8 = 1'b1; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    scramble8();
    measure8(-1, d2, bz);
    check("b2b done gap", 64'(d2 + 1), 64'd9);
    check("b2b second sum", 64'(sum8), 64'hF0);
    check("b2b second cout", 64'(cout8), 64'd0);

    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom); rc = 1'($urandom);
      model(8, 64'(ra), 64'(rb), rs, rc, m_sum, m_co, m_ov);
      op8($sformatf("rand%0d a=%0h b=%0h sub=%0d cin=%0d", i, ra, rb, rs, rc),
          ra, rb, rs, rc, 8'(m_sum), m_co, m_ov, (i % 3 == 0) ? 4 : -1);
    end

    // Reset part-way through an operation after a non-zero result.
    op8("pre_reset", 8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, -1);
    launch8(8'h5A, 8'h33, 1'b0, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst sum", 64'(sum8), 64'd0);
    check("midrst cout", 64'(cout8), 64'd0);
    check("midrst ovf", 64'(ovf8), 64'd0);
    check("midrst busy", 64'(busy8), 64'd0);
    n_done = 0;
    for (int t = 0; t < 16; t++) begin
      if (done8) n_done++;
      @(posedge clk);
      #1;
    end
    check("midrst no done", 64'(n_done), 64'd0);

    for (int i = 0; i < 2; i++) op2($sformatf("w2_vec%0d", i), vecs2[i]);
    for (int i = 0; i < 6; i++) begin
      vec2_t v;
      v.a = 2'($urandom); v.b = 2'($urandom); v.sub = 1'($urandom); v.cin = 1'($urandom);
      model(2, 64'(v.a), 64'(v.b), v.sub, v.cin, m_sum, m_co, m_ov);
      v.sum = 2'(m_sum); v.cout = m_co; v.ovf = m_ov;
      op2($sformatf("w2_rand%0d", i), v);
    end

    check("busy_done_overlap", 64'(n_overlap), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
